// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial transmitter.
// SERIAL_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
package serial_tx_pkg;

    localparam int DATA_BITS = 8;

`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_e;

    // Clock cycles from the start bit to the end of the stop bit.
    function automatic int frame_cycles(input int clks_per_bit);
        return FRAME_BITS * clks_per_bit;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Logical view of the transmitter pins: a byte plus send request in, line and status out.
interface serial_tx_if;
    import serial_tx_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 req;
    logic                 txd;
    logic                 busy;
    logic                 done;

    modport master (output data, output req, input txd, input busy, input done);
    modport slave  (input data, input req, output txd, output busy, output done);

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, asynchronously reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: clocked state uses non-blocking assignments so both flops sample
    // the pre-edge values; blocking here would collapse the chain to one flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tt_um_serial_tx.sv
// 8N1 serial transmitter started by a rising edge on uio_in[0].
// Define SERIAL_TX_PARITY_EN for an even-parity bit (8E1 framing).
module tt_um_serial_tx
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int                BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                BIT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic unused_inputs;
    assign unused_inputs = ^{ena, uio_in[7:1]};

    logic req_sync;
    logic req_prev_q;
    logic req_rise;

    sync_2ff u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (uio_in[0]),
        .q_o   (req_sync)
    );

    assign req_rise = req_sync & ~req_prev_q;

    state_e               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q,  baud_d;
    logic [BIT_W-1:0]     bit_q,   bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 txd_q,   txd_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic                 bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            req_prev_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            req_prev_q <= req_sync;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // NOTE: every signal assigned below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        bit_end = (baud_q == BAUD_MAX);

        if (state_q != ST_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        // Edges outside IDLE are dropped, never queued.
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (req_rise) begin
                    shift_d = ui_in;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^ui_in;
`endif
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with state_q.
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: txd_d = parity_d;
`endif
            default:   txd_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && (baud_d == BAUD_MAX);
    end

    assign uo_out  = {5'b0, done_q, busy_q, txd_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
